i2c_reg_sequencer: RTL and testbench

//  Sequences the i2c byte-level master into complete register transactions: single-byte register write or read.
//  The host posts one request: device addr, register addr, R/W, wdata. The block issues the START/WRITE/RESTART/READ/STOP

---
 rtl/i2c_reg_sequencer_pkg.sv | 27 ++
 rtl/i2c_reg_sequencer_step.sv | 45 ++++
 rtl/i2c_reg_sequencer.sv | 172 +++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_reg_sequencer_pkg.sv
// Shared definitions for the I2C register sequencer: master command codes,
// FSM state encoding and step-list bounds.
package i2c_reg_sequencer_pkg;

  typedef enum logic [2:0] {
    CMD_START   = 3'd0,
    CMD_RESTART = 3'd1,
    CMD_STOP    = 3'd2,
    CMD_READ    = 3'd3,
    CMD_WRITE   = 3'd4
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_RDY,
    ST_WAIT_DONE,
    ST_NEXT,
    ST_RESP
  } state_t;

  // Index of the closing STOP in each step list.
  localparam logic [2:0] WR_LAST_STEP = 3'd4;
  localparam logic [2:0] RD_LAST_STEP = 3'd6;

endpackage

// File: rtl/i2c_reg_sequencer_step.sv
// Step-list decoder: maps (rw, step index, request fields) to the master
// command and byte for that step.
module i2c_reg_sequencer_step
  import i2c_reg_sequencer_pkg::*;
(
  input  logic       rw,
  input  logic [2:0] step,
  input  logic [6:0] dev,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic [2:0] cmd,
  output logic [7:0] data,
  output logic       is_last,
  output logic [2:0] stop_step
);

  always_comb begin
    cmd  = CMD_STOP;
    data = 8'h00;
    if (rw) begin
      case (step)
        3'd0: cmd = CMD_START;
        3'd1: begin cmd = CMD_WRITE; data = {dev, 1'b0}; end
        3'd2: begin cmd = CMD_WRITE; data = reg_addr;    end
        3'd3: cmd = CMD_RESTART;
        3'd4: begin cmd = CMD_WRITE; data = {dev, 1'b1}; end
        // bit0 set: master NACKs the single byte it receives
        3'd5: begin cmd = CMD_READ;  data = 8'h01;       end
        default: cmd = CMD_STOP;
      endcase
    end else begin
      case (step)
        3'd0: cmd = CMD_START;
        3'd1: begin cmd = CMD_WRITE; data = {dev, 1'b0}; end
        3'd2: begin cmd = CMD_WRITE; data = reg_addr;    end
        3'd3: begin cmd = CMD_WRITE; data = wdata;       end
        default: cmd = CMD_STOP;
      endcase
    end
  end

  assign stop_step = rw ? RD_LAST_STEP : WR_LAST_STEP;
  assign is_last   = (step == stop_step);

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Turns one host register request into the full START..STOP command stream
// for the byte-level I2C master and reports read data and status.
//
// state     | meaning
// IDLE      | ready for a host request
// ISSUE     | wait for master ready, then strobe the current step's command
// WAIT_BUSY | wait for master to drop ready (strobe taken)
// WAIT_RDY  | START/RESTART/STOP in progress, wait for ready
// WAIT_DONE | WRITE/READ byte in progress, wait for done_tick
// NEXT      | choose next step, jump to STOP on NACK, or finish
// RESP      | rsp_valid pulse is on the outputs
module i2c_reg_sequencer
  import i2c_reg_sequencer_pkg::*;
#(
  parameter int CLK_DIV        = 480,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [6:0]  req_dev_addr,
  input  logic [7:0]  req_reg_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_nack,
  output logic        rsp_timeout,
  output logic        i2c_write,
  output logic [2:0]  i2c_cmd,
  output logic [7:0]  i2c_data_in,
  output logic [15:0] i2c_clock_divisor,
  input  logic        i2c_ready,
  input  logic        i2c_done_tick,
  input  logic        i2c_ack,
  input  logic [7:0]  i2c_data_out
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state;
  logic [2:0]  step;
  logic [15:0] timer;
  logic        rw_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        nack_flag;

  logic [2:0]  step_cmd;
  logic [7:0]  step_data;
  logic        step_is_last;
  logic [2:0]  stop_step;

  i2c_reg_sequencer_step u_step (
    .rw        (rw_q),
    .step      (step),
    .dev       (dev_q),
    .reg_addr  (reg_q),
    .wdata     (wdata_q),
    .cmd       (step_cmd),
    .data      (step_data),
    .is_last   (step_is_last),
    .stop_step (stop_step)
  );

  assign req_ready         = (state == ST_IDLE);
  assign i2c_clock_divisor = 16'(CLK_DIV);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      step        <= 3'd0;
      timer       <= 16'd0;
      rw_q        <= 1'b0;
      dev_q       <= 7'd0;
      reg_q       <= 8'd0;
      wdata_q     <= 8'd0;
      rdata_q     <= 8'd0;
      nack_flag   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'd0;
      rsp_nack    <= 1'b0;
      rsp_timeout <= 1'b0;
      i2c_write   <= 1'b0;
      i2c_cmd     <= 3'd0;
      i2c_data_in <= 8'd0;
    end else begin
      i2c_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            rw_q        <= req_rw;
            dev_q       <= req_dev_addr;
            reg_q       <= req_reg_addr;
            wdata_q     <= req_wdata;
            rdata_q     <= 8'd0;
            nack_flag   <= 1'b0;
            rsp_rdata   <= 8'd0;
            rsp_nack    <= 1'b0;
            rsp_timeout <= 1'b0;
            step        <= 3'd0;
            timer       <= 16'd0;
            state       <= ST_ISSUE;
          end
        end

        ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_RDY, ST_WAIT_DONE: begin
          if (timer == TIMEOUT_LIMIT) begin
            // Abort without STOP; the bus is left to the master's reset.
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_nack    <= nack_flag;
            rsp_rdata   <= 8'd0;
            state       <= ST_RESP;
          end else begin
            timer <= timer + 16'd1;
            case (state)
              ST_ISSUE: begin
                if (i2c_ready) begin
                  i2c_write   <= 1'b1;
                  i2c_cmd     <= step_cmd;
                  i2c_data_in <= step_data;
                  timer       <= 16'd0;
                  state       <= ST_WAIT_BUSY;
                end
              end
              ST_WAIT_BUSY: begin
                if (!i2c_ready)
                  state <= (i2c_cmd == CMD_WRITE || i2c_cmd == CMD_READ) ?
                           ST_WAIT_DONE : ST_WAIT_RDY;
              end
              ST_WAIT_RDY: begin
                if (i2c_ready) state <= ST_NEXT;
              end
              default: begin
                if (i2c_done_tick) begin
                  if (i2c_cmd == CMD_WRITE) nack_flag <= i2c_ack;
                  if (i2c_cmd == CMD_READ)  rdata_q   <= i2c_data_out;
                  state <= ST_NEXT;
                end
              end
            endcase
          end
        end

        ST_NEXT: begin
          if (nack_flag && i2c_cmd != CMD_STOP) begin
            step  <= stop_step;
            state <= ST_ISSUE;
          end else if (step_is_last) begin
            rsp_valid <= 1'b1;
            rsp_nack  <= nack_flag;
            rsp_rdata <= nack_flag ? 8'd0 : rdata_q;
            state     <= ST_RESP;
          end else begin
            step  <= step + 3'd1;
            state <= ST_ISSUE;
          end
        end

        default: begin
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench: a behavioural master/slave model answers the command
// strobes; table vectors plus timeout and mid-transaction reset sequences.
module tb_i2c_reg_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw = 1'b0;
  logic [6:0]  req_dev_addr = 7'd0;
  logic [7:0]  req_reg_addr = 8'd0;
  logic [7:0]  req_wdata = 8'd0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_nack;
  logic        rsp_timeout;
  logic        i2c_write;
  logic [2:0]  i2c_cmd;
  logic [7:0]  i2c_data_in;
  logic [15:0] i2c_clock_divisor;
  logic        i2c_ready = 1'b1;
  logic        i2c_done_tick = 1'b0;
  logic        i2c_ack = 1'b0;
  logic [7:0]  i2c_data_out = 8'd0;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(.CLK_DIV(480), .TIMEOUT_CYCLES(100)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_rw            (req_rw),
    .req_dev_addr      (req_dev_addr),
    .req_reg_addr      (req_reg_addr),
    .req_wdata         (req_wdata),
    .rsp_valid         (rsp_valid),
    .rsp_rdata         (rsp_rdata),
    .rsp_nack          (rsp_nack),
    .rsp_timeout       (rsp_timeout),
    .i2c_write         (i2c_write),
    .i2c_cmd           (i2c_cmd),
    .i2c_data_in       (i2c_data_in),
    .i2c_clock_divisor (i2c_clock_divisor),
    .i2c_ready         (i2c_ready),
    .i2c_done_tick     (i2c_done_tick),
    .i2c_ack           (i2c_ack),
    .i2c_data_out      (i2c_data_out)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Master + slave model: each strobe is logged as {cmd, byte}, the master
  // goes busy for three cycles, byte phases end with done_tick.
  logic [10:0] log_q[$];
  int          mdl_cnt = 0;
  int          widx = 0;
  logic [2:0]  pend_cmd = 3'd0;
  logic [7:0]  pend_data = 8'd0;
  logic [6:0]  present = 7'h50;
  logic        nack_data = 1'b0;
  logic        stall = 1'b0;
  logic [7:0]  rd_byte = 8'd0;

  always @(negedge clk) begin
    i2c_done_tick = 1'b0;
    if (!reset_n) begin
      i2c_ready = 1'b1;
      mdl_cnt   = 0;
      widx      = 0;
    end else if (stall) begin
      i2c_ready = 1'b0;
    end else if (i2c_write) begin
      log_q.push_back({i2c_cmd, i2c_data_in});
      pend_cmd  = i2c_cmd;
      pend_data = i2c_data_in;
      if (i2c_cmd == 3'd0 || i2c_cmd == 3'd1) widx = 0;
      i2c_ready = 1'b0;
      mdl_cnt   = 3;
    end else if (mdl_cnt > 0) begin
      mdl_cnt--;
      if (mdl_cnt == 0) begin
        i2c_ready = 1'b1;
        if (pend_cmd == 3'd4) begin
          if (widx == 0)      i2c_ack = (pend_data[7:1] != present);
          else if (widx == 2) i2c_ack = nack_data;
          else                i2c_ack = 1'b0;
          widx++;
          i2c_done_tick = 1'b1;
        end else if (pend_cmd == 3'd3) begin
          i2c_data_out  = rd_byte;
          i2c_done_tick = 1'b1;
        end
      end
    end else begin
      i2c_ready = 1'b1;
    end
  end

  typedef struct {
    logic             rw;
    logic [6:0]       dev;
    logic [7:0]       ra;
    logic [7:0]       wd;
    logic [7:0]       rd;
    logic             nd;
    logic             en;
    logic [7:0]       er;
    int               n;
    logic [6:0][10:0] cmds;
  } vec_t;

  function automatic vec_t mk(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                              input logic [7:0] wd, input logic [7:0] rd, input logic nd,
                              input logic en, input logic [7:0] er, input int n,
                              input logic [10:0] c0, input logic [10:0] c1, input logic [10:0] c2,
                              input logic [10:0] c3, input logic [10:0] c4, input logic [10:0] c5,
                              input logic [10:0] c6);
    vec_t v;
    v.rw = rw; v.dev = dev; v.ra = ra; v.wd = wd; v.rd = rd; v.nd = nd;
    v.en = en; v.er = er; v.n = n;
    v.cmds[0] = c0; v.cmds[1] = c1; v.cmds[2] = c2; v.cmds[3] = c3;
    v.cmds[4] = c4; v.cmds[5] = c5; v.cmds[6] = c6;
    return v;
  endfunction

  task automatic accept(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                        input logic [7:0] wd);
    @(negedge clk);
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    check("req_ready_before_accept", req_ready, 1'b1);
    req_rw = rw; req_dev_addr = dev; req_reg_addr = ra; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok, output int cyc, output logic [7:0] rd,
                          output logic nk, output logic tm, output logic rr);
    ok = 0; cyc = 0; rd = 8'd0; nk = 1'b0; tm = 1'b0; rr = 1'b0;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1; cyc = i - 1;
        rd = rsp_rdata; nk = rsp_nack; tm = rsp_timeout; rr = req_ready;
        break;
      end
    end
  endtask

  task automatic check_stream(input string tag, input vec_t v);
    check({tag, "_cmd_count"}, log_q.size(), v.n);
    for (int j = 0; j < v.n && j < log_q.size(); j++) begin
      check($sformatf("%s_cmd%0d", tag, j), 32'(log_q[j][10:8]), 32'(v.cmds[j][10:8]));
      if (v.cmds[j][10:8] == 3'd3 || v.cmds[j][10:8] == 3'd4)
        check($sformatf("%s_byte%0d", tag, j), 32'(log_q[j][7:0]), 32'(v.cmds[j][7:0]));
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    bit ok; int cyc; logic [7:0] rd; logic nk, tm, rr;
    log_q.delete();
    nack_data = v.nd; rd_byte = v.rd;
    accept(v.rw, v.dev, v.ra, v.wd);
    wait_rsp(ok, cyc, rd, nk, tm, rr);
    check({tag, "_rsp_seen"}, ok, 1'b1);
    check({tag, "_rsp_nack"}, nk, v.en);
    check({tag, "_rsp_timeout"}, tm, 1'b0);
    check({tag, "_rsp_rdata"}, rd, v.er);
    check({tag, "_ready_during_rsp"}, rr, 1'b0);
    @(negedge clk);
    check({tag, "_rsp_one_cycle"}, rsp_valid, 1'b0);
    check({tag, "_ready_after_rsp"}, req_ready, 1'b1);
    check_stream(tag, v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b1);
    check({tag, "_i2c_write"}, i2c_write, 1'b0);
    check({tag, "_i2c_cmd"}, i2c_cmd, 3'd0);
    check({tag, "_i2c_data_in"}, i2c_data_in, 8'd0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 8'd0);
    check({tag, "_rsp_nack"}, rsp_nack, 1'b0);
    check({tag, "_rsp_timeout"}, rsp_timeout, 1'b0);
    check({tag, "_divisor"}, i2c_clock_divisor, 16'd480);
  endtask

  vec_t vecs[7];

  initial begin
    bit ok; int cyc; logic [7:0] rd; logic nk, tm, rr;

    vecs[0] = mk(1'b0, 7'h50, 8'h10, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h00, 5,
                 11'h000, 11'h4A0, 11'h410, 11'h43C, 11'h200, 11'h000, 11'h000);
    vecs[1] = mk(1'b1, 7'h50, 8'h22, 8'h00, 8'hA5, 1'b0, 1'b0, 8'hA5, 7,
                 11'h000, 11'h4A0, 11'h422, 11'h100, 11'h4A1, 11'h301, 11'h200);
    vecs[2] = mk(1'b0, 7'h27, 8'h10, 8'h55, 8'h00, 1'b0, 1'b1, 8'h00, 3,
                 11'h000, 11'h44E, 11'h200, 11'h000, 11'h000, 11'h000, 11'h000);
    vecs[3] = mk(1'b0, 7'h50, 8'h11, 8'h77, 8'h00, 1'b1, 1'b1, 8'h00, 5,
                 11'h000, 11'h4A0, 11'h411, 11'h477, 11'h200, 11'h000, 11'h000);
    vecs[4] = mk(1'b0, 7'h50, 8'h12, 8'h99, 8'h00, 1'b0, 1'b0, 8'h00, 5,
                 11'h000, 11'h4A0, 11'h412, 11'h499, 11'h200, 11'h000, 11'h000);
    vecs[5] = mk(1'b1, 7'h27, 8'h33, 8'h00, 8'h5A, 1'b0, 1'b1, 8'h00, 3,
                 11'h000, 11'h44E, 11'h200, 11'h000, 11'h000, 11'h000, 11'h000);
    vecs[6] = mk(1'b1, 7'h50, 8'h7F, 8'h00, 8'hFF, 1'b0, 1'b0, 8'hFF, 7,
                 11'h000, 11'h4A0, 11'h47F, 11'h100, 11'h4A1, 11'h301, 11'h200);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    for (int k = 0; k < 7; k++) run_vec($sformatf("vec%0d", k), vecs[k]);

    // Stalled master: ready never returns, the wait must time out.
    log_q.delete();
    stall = 1'b1;
    @(negedge clk);
    accept(1'b0, 7'h50, 8'h10, 8'h3C);
    wait_rsp(ok, cyc, rd, nk, tm, rr);
    check("tmo_rsp_seen", ok, 1'b1);
    check("tmo_latency_in_window", (cyc >= 100 && cyc <= 102), 1'b1);
    check("tmo_rsp_timeout", tm, 1'b1);
    check("tmo_rsp_nack", nk, 1'b0);
    check("tmo_rsp_rdata", rd, 8'h00);
    check("tmo_no_cmds", log_q.size(), 0);
    @(negedge clk);
    check("tmo_ready_after", req_ready, 1'b1);
    stall = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while the register-address byte is in flight.
    log_q.delete();
    nack_data = 1'b0;
    accept(1'b0, 7'h50, 8'h10, 8'h3C);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (log_q.size() >= 3) begin ok = 1; break; end
    end
    check("midrst_reached_reg_byte", ok, 1'b1);
    check("midrst_cmd_before_reset", i2c_cmd, 3'd4);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    run_vec("post_reset_read", vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_time_limit: got expired expected finished");
    $fatal(1, "time limit");
  end

endmodule
